// File: rtl/recv_sched_pkg.sv
// Shared types and width helpers for the receiver scheduler.
package recv_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ABORT
    } recv_sched_state_t;

    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
// Zero latency; when en_i is low the grant is all zeros.
module rr_arbiter
    import recv_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(ptr_i) + k) % N_REQ);
            if (en_i && !found && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/recv_sched.sv
// Shares one UART receiver between N_REQ requesters, one burst at a time, round-robin.
// All outputs registered; a start pulse is held back while the receiver reports busy.
module recv_sched
    import recv_sched_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_SIZE      = 16,
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [N_REQ-1:0]       req_in,
    input  logic [N_REQ*LEN_W-1:0] len_in,
    output logic [N_REQ-1:0]       grant_out,
    output logic [DATA_SIZE-1:0]   data_out,
    output logic [N_REQ-1:0]       valid_out,
    output logic [N_REQ-1:0]       done_out,
    output logic [N_REQ-1:0]       timeout_out,
    output logic                   recv_start_out,
    output logic                   recv_rst_out,
    input  logic                   recv_busy_in,
    input  logic [DATA_SIZE-1:0]   recv_data_in,
    input  logic                   recv_new_in
);

    localparam int IW = idx_width(N_REQ);
    localparam int TW = timer_width(TIMEOUT_CYCLES);

    recv_sched_state_t    state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [LEN_W-1:0]     remaining_q, remaining_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [N_REQ-1:0]     valid_q, valid_d;
    logic [N_REQ-1:0]     done_q, done_d;
    logic [N_REQ-1:0]     timeout_q, timeout_d;
    logic                 start_q, start_d;
    logic                 rrst_q, rrst_d;

    logic [N_REQ-1:0]     arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic [LEN_W-1:0]     arb_len;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req_i (req_in),
        .ptr_i (ptr_q),
        .en_i  (state_q == ST_IDLE),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        arb_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = IW'(i);
                arb_len = len_in[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        grant_d     = grant_q;
        data_d      = data_q;
        valid_d     = '0;
        done_d      = '0;
        timeout_d   = '0;
        start_d     = 1'b0;
        rrst_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The previous grant is still visible alongside its done strobe; drop it here.
                grant_d = '0;
                if (|arb_gnt) begin
                    ptr_d       = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
                    remaining_d = arb_len;
                    if (arb_len == '0) begin
                        done_d = arb_gnt;
                    end else begin
                        grant_d = arb_gnt;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!recv_busy_in) begin
                    start_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A word arriving on the expiry cycle takes priority over the timeout.
                if (recv_new_in) begin
                    data_d      = recv_data_in;
                    valid_d     = grant_q;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        done_d  = grant_q;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = grant_q;
                    rrst_d    = 1'b1;
                    state_d   = ST_ABORT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_ABORT: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            grant_q     <= '0;
            data_q      <= '0;
            valid_q     <= '0;
            done_q      <= '0;
            timeout_q   <= '0;
            start_q     <= 1'b0;
            rrst_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            grant_q     <= grant_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            start_q     <= start_d;
            rrst_q      <= rrst_d;
        end
    end

    assign grant_out      = grant_q;
    assign data_out       = data_q;
    assign valid_out      = valid_q;
    assign done_out       = done_q;
    assign timeout_out    = timeout_q;
    assign recv_start_out = start_q;
    assign recv_rst_out   = rrst_q;

endmodule

// File: tb/tb_recv_sched.sv
// Directed bench for recv_sched with a small behavioural receiver model.
module tb_recv_sched;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int LW = 8;
    localparam int TO = 50;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [N-1:0]    req_in;
    logic [N*LW-1:0] len_in;
    logic [N-1:0]    grant_out, valid_out, done_out, timeout_out;
    logic [DW-1:0]   data_out;
    logic            recv_start_out, recv_rst_out;
    logic            recv_busy_in;
    logic [DW-1:0]   recv_data_in = '0;
    logic            recv_new_in  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;

    logic          mute = 1'b0, busy_force = 1'b0, stray = 1'b0;
    logic [DW-1:0] stray_data = '0;
    int            resp_delay = 0;
    logic [DW-1:0] words[$];
    logic          m_pend = 1'b0, m_busy = 1'b0;
    int            m_cnt = 0;

    recv_sched #(.N_REQ(N), .DATA_SIZE(DW), .LEN_W(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .len_in(len_in),
        .grant_out(grant_out), .data_out(data_out), .valid_out(valid_out),
        .done_out(done_out), .timeout_out(timeout_out),
        .recv_start_out(recv_start_out), .recv_rst_out(recv_rst_out),
        .recv_busy_in(recv_busy_in), .recv_data_in(recv_data_in), .recv_new_in(recv_new_in)
    );

    always #5 clk_in = ~clk_in;
    assign recv_busy_in = m_busy | busy_force;

    // Receiver model: replies resp_delay+1 cycles after the start pulse is seen.
    always @(negedge clk_in) begin
        if (recv_start_out) start_cnt++;
        recv_new_in = 1'b0;
        if (rst_in) begin
            m_pend = 1'b0;
            m_busy = 1'b0;
            words.delete();
        end else if (stray) begin
            recv_new_in  = 1'b1;
            recv_data_in = stray_data;
        end else if (m_pend) begin
            if (m_cnt == 0) begin
                recv_new_in  = 1'b1;
                recv_data_in = (words.size() > 0) ? words.pop_front() : '0;
                m_pend = 1'b0;
                m_busy = 1'b0;
            end else begin
                m_cnt--;
            end
        end else if (recv_start_out && !mute) begin
            m_pend = 1'b1;
            m_busy = 1'b1;
            m_cnt  = resp_delay;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_len(input int i, input logic [LW-1:0] v);
        len_in[i*LW +: LW] = v;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; req_in = '0; len_in = '0;
        tick(); tick();
        n_tests++; if (grant_out !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant_out); end
        n_tests++; if (valid_out !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", valid_out); end
        n_tests++; if (done_out !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b want 0000", done_out); end
        n_tests++; if (timeout_out !== 4'b0000) begin n_fail++; $display("FAIL reset_timeout: got %b want 0000", timeout_out); end
        n_tests++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", data_out); end
        n_tests++; if ({recv_start_out, recv_rst_out} !== 2'b00) begin n_fail++; $display("FAIL reset_recv: got %b want 00", {recv_start_out, recv_rst_out}); end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int s0;
        len_in = '0; set_len(0, 8'd1);
        words.push_back(16'hBEEF); resp_delay = 0; s0 = start_cnt;
        req_in = 4'b0001;
        tick();
        n_tests++; if (grant_out !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", grant_out); end
        req_in = '0;
        tick();
        n_tests++; if (recv_start_out !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", recv_start_out); end
        tick(); tick();
        n_tests++; if (valid_out !== 4'b0001) begin n_fail++; $display("FAIL single_valid: got %b want 0001", valid_out); end
        n_tests++; if (data_out !== 16'hBEEF) begin n_fail++; $display("FAIL single_data: got %h want beef", data_out); end
        n_tests++; if (done_out !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b want 0001", done_out); end
        n_tests++; if (grant_out !== 4'b0001) begin n_fail++; $display("FAIL single_grant_held: got %b want 0001", grant_out); end
        tick();
        n_tests++; if (grant_out !== 4'b0000) begin n_fail++; $display("FAIL single_grant_clr: got %b want 0000", grant_out); end
        n_tests++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g[3] = '{4'b0010, 4'b0100, 4'b0010};
        logic [3:0] prev_g = '0, prev_d = '0;
        int n = 0;
        len_in = {8'd1, 8'd1, 8'd1, 8'd1};
        words.push_back(16'h0011); words.push_back(16'h0022); words.push_back(16'h0033);
        req_in = 4'b0110;
        for (int cyc = 0; cyc < 100; cyc++) begin
            tick();
            if (grant_out != 4'b0000 && grant_out != prev_g) begin
                n_tests++; if (n < 3 && grant_out !== exp_g[n]) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", n, grant_out, exp_g[n]); end
                if (n > 0 && n < 3) begin
                    n_tests++; if (prev_d !== exp_g[n-1]) begin n_fail++; $display("FAIL rr_done_before%0d: got %b want %b", n, prev_d, exp_g[n-1]); end
                end
                n++;
                if (n == 3) req_in = '0;
            end
            prev_g = grant_out;
            prev_d = done_out;
            if (n >= 3 && grant_out == 4'b0000) break;
        end
        n_tests++; if (n !== 3) begin n_fail++; $display("FAIL rr_count: got %0d want 3", n); end
    endtask

    task automatic test_burst();
        int s0, nv = 0;
        len_in = '0; set_len(2, 8'd3);
        words.push_back(16'h0001); words.push_back(16'h0002); words.push_back(16'h0003);
        resp_delay = 2; s0 = start_cnt;
        req_in = 4'b0100;
        tick();
        n_tests++; if (grant_out !== 4'b0100) begin n_fail++; $display("FAIL burst_grant: got %b want 0100", grant_out); end
        req_in = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            tick();
            if (valid_out != 4'b0000) begin
                n_tests++; if (valid_out !== 4'b0100 || data_out !== 16'(nv + 1)) begin n_fail++; $display("FAIL burst_word%0d: got %b/%h want 0100/%h", nv, valid_out, data_out, 16'(nv + 1)); end
                nv++;
            end
            if (done_out != 4'b0000) begin
                n_tests++; if (done_out !== 4'b0100 || nv !== 3 || valid_out !== 4'b0100) begin n_fail++; $display("FAIL burst_done: got %b after %0d words want 0100 after 3", done_out, nv); end
            end
            if (grant_out == 4'b0000) break;
        end
        n_tests++; if (nv !== 3) begin n_fail++; $display("FAIL burst_valid_count: got %0d want 3", nv); end
        n_tests++; if (start_cnt - s0 !== 3) begin n_fail++; $display("FAIL burst_starts: got %0d want 3", start_cnt - s0); end
        resp_delay = 0;
    endtask

    task automatic test_busy_hold();
        logic early = 1'b0;
        len_in = '0; set_len(0, 8'd1);
        words.push_back(16'h0C0C); busy_force = 1'b1;
        req_in = 4'b0001;
        tick();
        n_tests++; if (grant_out !== 4'b0001) begin n_fail++; $display("FAIL busy_grant: got %b want 0001", grant_out); end
        req_in = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (recv_start_out) early = 1'b1;
        end
        n_tests++; if (early !== 1'b0) begin n_fail++; $display("FAIL busy_no_start: got %b want 0", early); end
        busy_force = 1'b0;
        tick();
        n_tests++; if (recv_start_out !== 1'b1) begin n_fail++; $display("FAIL busy_release_start: got %b want 1", recv_start_out); end
        for (int cyc = 0; cyc < 20 && grant_out != 4'b0000; cyc++) tick();
    endtask

    task automatic test_timeout();
        logic early = 1'b0;
        mute = 1'b1;
        len_in = '0; set_len(3, 8'd1);
        req_in = 4'b1000;
        tick();
        n_tests++; if (grant_out !== 4'b1000) begin n_fail++; $display("FAIL to_grant: got %b want 1000", grant_out); end
        req_in = '0;
        tick();
        n_tests++; if (recv_start_out !== 1'b1) begin n_fail++; $display("FAIL to_start: got %b want 1", recv_start_out); end
        for (int k = 1; k < TO; k++) begin
            tick();
            if (timeout_out != 4'b0000 || recv_rst_out) early = 1'b1;
        end
        n_tests++; if (early !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", early); end
        tick();
        n_tests++; if (timeout_out !== 4'b1000) begin n_fail++; $display("FAIL to_strobe: got %b want 1000", timeout_out); end
        n_tests++; if (recv_rst_out !== 1'b1) begin n_fail++; $display("FAIL to_recv_rst: got %b want 1", recv_rst_out); end
        tick();
        n_tests++; if ({timeout_out, recv_rst_out, grant_out} !== 9'b0) begin n_fail++; $display("FAIL to_abort_clear: got %b want 0", {timeout_out, recv_rst_out, grant_out}); end
        mute = 1'b0;
    endtask

    task automatic test_race();
        int k = 0;
        len_in = '0; set_len(0, 8'd1);
        words.push_back(16'h5A5A); resp_delay = TO - 2;
        req_in = 4'b0001;
        tick();
        req_in = '0;
        tick();
        n_tests++; if (recv_start_out !== 1'b1) begin n_fail++; $display("FAIL race_start: got %b want 1", recv_start_out); end
        for (int cyc = 1; cyc <= TO + 10; cyc++) begin
            tick();
            k = cyc;
            if (valid_out != 4'b0000 || timeout_out != 4'b0000) break;
        end
        n_tests++; if (k !== TO) begin n_fail++; $display("FAIL race_latency: got %0d want %0d", k, TO); end
        n_tests++; if (valid_out !== 4'b0001 || data_out !== 16'h5A5A) begin n_fail++; $display("FAIL race_word: got %b/%h want 0001/5a5a", valid_out, data_out); end
        n_tests++; if (timeout_out !== 4'b0000 || done_out !== 4'b0001) begin n_fail++; $display("FAIL race_no_timeout: got to=%b done=%b want 0000/0001", timeout_out, done_out); end
        tick();
        n_tests++; if (timeout_out !== 4'b0000 || recv_rst_out !== 1'b0) begin n_fail++; $display("FAIL race_after: got %b/%b want 0000/0", timeout_out, recv_rst_out); end
        resp_delay = 0;
    endtask

    task automatic test_zero_len();
        int s0 = start_cnt;
        len_in = '0;
        req_in = 4'b0010;
        tick();
        n_tests++; if (done_out !== 4'b0010) begin n_fail++; $display("FAIL zero_done: got %b want 0010", done_out); end
        n_tests++; if (grant_out !== 4'b0000) begin n_fail++; $display("FAIL zero_grant: got %b want 0000", grant_out); end
        req_in = '0;
        tick(); tick();
        n_tests++; if (start_cnt - s0 !== 0 || done_out !== 4'b0000) begin n_fail++; $display("FAIL zero_no_start: got starts=%0d done=%b want 0/0000", start_cnt - s0, done_out); end
    endtask

    task automatic test_mid_reset();
        len_in = '0; set_len(0, 8'd4);
        for (int i = 0; i < 4; i++) words.push_back(16'(16'hA000 + i));
        resp_delay = 5;
        req_in = 4'b0001;
        tick();
        n_tests++; if (grant_out !== 4'b0001) begin n_fail++; $display("FAIL mrst_grant: got %b want 0001", grant_out); end
        req_in = '0;
        tick(); tick(); tick();
        rst_in = 1'b1;
        #1;
        n_tests++; if ({grant_out, valid_out, done_out, timeout_out, recv_start_out, recv_rst_out} !== 18'b0 || data_out !== 16'h0000)
            begin n_fail++; $display("FAIL mrst_async: got g=%b d=%h want all zero", grant_out, data_out); end
        tick();
        rst_in = 1'b0;
        tick();
        resp_delay = 0;
        len_in = '0; set_len(0, 8'd1); set_len(1, 8'd1);
        words.push_back(16'h1234);
        req_in = 4'b0011;
        tick();
        n_tests++; if (grant_out !== 4'b0001) begin n_fail++; $display("FAIL mrst_ptr: got %b want 0001", grant_out); end
        req_in = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (valid_out != 4'b0000) break;
        end
        n_tests++; if (valid_out !== 4'b0001 || data_out !== 16'h1234) begin n_fail++; $display("FAIL mrst_serve: got %b/%h want 0001/1234", valid_out, data_out); end
        tick(); tick();
    endtask

    task automatic test_stray();
        stray_data = 16'hDEAD; stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        n_tests++; if (valid_out !== 4'b0000 || data_out !== 16'h1234) begin n_fail++; $display("FAIL stray_ignored: got %b/%h want 0000/1234", valid_out, data_out); end
        tick();
        n_tests++; if (valid_out !== 4'b0000 || grant_out !== 4'b0000) begin n_fail++; $display("FAIL stray_idle: got %b/%b want 0000/0000", valid_out, grant_out); end
    endtask

    initial begin
        rst_in = 1'b1; req_in = '0; len_in = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_busy_hold();
        test_timeout();
        test_race();
        test_zero_len();
        test_mid_reset();
        test_stray();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
